// File: rtl/alu_arb_pkg.sv
// Shared opcode constants, FSM encoding and opcode legality helper for alu_arbiter.
package alu_arb_pkg;

    localparam logic [3:0] ALU_ADD     = 4'b0000;
    localparam logic [3:0] ALU_SUB     = 4'b0001;
    localparam logic [3:0] ALU_NOT     = 4'b0010;
    localparam logic [3:0] ALU_SLL     = 4'b0011;
    localparam logic [3:0] ALU_SRL     = 4'b0100;
    localparam logic [3:0] ALU_AND     = 4'b0101;
    localparam logic [3:0] ALU_OR      = 4'b0110;
    localparam logic [3:0] ALU_SLT     = 4'b0111;
    localparam logic [3:0] ALU_OP_LAST = 4'b0111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    function automatic logic op_illegal(input logic [3:0] op);
        return op > ALU_OP_LAST;
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_grant.sv
// Combinational requester picker: round-robin after last_grant, or fixed lowest-index
// priority when ALU_ARB_PRIO_EN is defined.
module rr_grant #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [ID_W-1:0]    last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx
);

`ifdef ALU_ARB_PRIO_EN
    logic unused_last;
    assign unused_last = ^last_grant;

    // Descending scan so the lowest asserted index is the final writer.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (valid[ID_W'(i)]) begin
                grant              = '0;
                grant[ID_W'(i)]    = 1'b1;
                grant_idx          = ID_W'(i);
            end
        end
    end
`else
    // Scan from the farthest slot to the nearest one after last_grant; nearest wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            logic [ID_W-1:0] cand;
            cand = ID_W'((int'(last_grant) + k) % NUM_REQ);
            if (valid[cand]) begin
                grant       = '0;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU among NUM_REQ requesters (IDLE -> EXEC -> RESP).
// Define ALU_ARB_PRIO_EN for fixed lowest-index priority instead of round-robin.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    reqValid,
    output logic [NUM_REQ-1:0]    reqReady,
    input  logic [NUM_REQ*32-1:0] reqInputOne,
    input  logic [NUM_REQ*32-1:0] reqInputTwo,
    input  logic [NUM_REQ*4-1:0]  reqALUControl,
    input  logic [NUM_REQ*5-1:0]  reqShiftAmount,
    output logic [31:0]           aluInputOne,
    output logic [31:0]           aluInputTwo,
    output logic [3:0]            aluControl,
    output logic [4:0]            aluShiftAmount,
    input  logic [31:0]           aluResult,
    input  logic                  aluZero,
    output logic                  rspValid,
    input  logic                  rspReady,
    output logic [ID_W-1:0]       rspId,
    output logic [31:0]           rspResult,
    output logic                  rspZero,
    output logic                  rspIllegal
);

    logic [1:0]         state_q, state_d;
    logic [31:0]        op_a_q, op_a_d;
    logic [31:0]        op_b_q, op_b_d;
    logic [3:0]         ctrl_q, ctrl_d;
    logic [4:0]         shamt_q, shamt_d;
    logic [ID_W-1:0]    owner_q, owner_d;
    logic [ID_W-1:0]    last_grant_q, last_grant_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
    logic [31:0]        rsp_result_q, rsp_result_d;
    logic               rsp_zero_q, rsp_zero_d;
    logic               rsp_illegal_q, rsp_illegal_d;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;

    rr_grant #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_grant (
        .valid      (reqValid),
        .last_grant (last_grant_q),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    assign reqReady = (state_q == ST_IDLE && !reset) ? grant : '0;

    always_comb begin
        state_d       = state_q;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        ctrl_d        = ctrl_q;
        shamt_d       = shamt_q;
        owner_d       = owner_q;
        last_grant_d  = last_grant_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_id_d      = rsp_id_q;
        rsp_result_d  = rsp_result_q;
        rsp_zero_d    = rsp_zero_q;
        rsp_illegal_d = rsp_illegal_q;
        case (state_q)
            ST_IDLE: begin
                if (|reqReady) begin
                    op_a_d       = reqInputOne[32*grant_idx +: 32];
                    op_b_d       = reqInputTwo[32*grant_idx +: 32];
                    ctrl_d       = reqALUControl[4*grant_idx +: 4];
                    shamt_d      = reqShiftAmount[5*grant_idx +: 5];
                    owner_d      = grant_idx;
                    last_grant_d = grant_idx;
                    state_d      = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_valid_d = 1'b1;
                rsp_id_d    = owner_q;
                // Illegal opcodes never let the ALU's undefined output reach the response.
                if (op_illegal(ctrl_q)) begin
                    rsp_result_d  = 32'd0;
                    rsp_zero_d    = 1'b0;
                    rsp_illegal_d = 1'b1;
                end else begin
                    rsp_result_d  = aluResult;
                    rsp_zero_d    = aluZero;
                    rsp_illegal_d = 1'b0;
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rspReady) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            op_a_q        <= '0;
            op_b_q        <= '0;
            ctrl_q        <= '0;
            shamt_q       <= '0;
            owner_q       <= '0;
            last_grant_q  <= ID_W'(NUM_REQ - 1);
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= '0;
            rsp_result_q  <= '0;
            rsp_zero_q    <= 1'b0;
            rsp_illegal_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
            ctrl_q        <= ctrl_d;
            shamt_q       <= shamt_d;
            owner_q       <= owner_d;
            last_grant_q  <= last_grant_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_id_q      <= rsp_id_d;
            rsp_result_q  <= rsp_result_d;
            rsp_zero_q    <= rsp_zero_d;
            rsp_illegal_q <= rsp_illegal_d;
        end
    end

    assign aluInputOne    = op_a_q;
    assign aluInputTwo    = op_b_q;
    assign aluControl     = ctrl_q;
    assign aluShiftAmount = shamt_q;
    assign rspValid       = rsp_valid_q;
    assign rspId          = rsp_id_q;
    assign rspResult      = rsp_result_q;
    assign rspZero        = rsp_zero_q;
    assign rspIllegal     = rsp_illegal_q;

endmodule
